test_pattern_gen: RTL

- Parametrised, registered, multi-mode VGA test pattern generator.
- Sits between the VGA timing generator (coordinates, active flag) and the DAC/pin outputs.
- Successor to the fixed combinational gradient: adds selectable patterns, frame-synchronous mode switching, frame-counter animation, output blanking and a fixed 2-cycle pipeline.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/bar_index_counter.sv | 53 +++++
 rtl/test_pattern_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pattern definitions: pattern mode encodings and the colour-bar table.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SCROLL   = 2'd3
  } mode_e;

  localparam int BAR_IDX_W = 3;

  // Per-bar channel enables, packed as {red, green, blue}
  typedef logic [2:0] rgb_en_t;

  function automatic rgb_en_t bar_colour(input logic [BAR_IDX_W-1:0] idx);
    rgb_en_t en;
    case (idx)
      3'd0:    en = 3'b111; // white
      3'd1:    en = 3'b110; // yellow
      3'd2:    en = 3'b011; // cyan
      3'd3:    en = 3'b010; // green
      3'd4:    en = 3'b101; // magenta
      3'd5:    en = 3'b100; // red
      3'd6:    en = 3'b001; // blue
      default: en = 3'b000; // black
    endcase
    return en;
  endfunction

endpackage

// File: rtl/bar_index_counter.sv
// Counts active pixels along a line and yields the saturating colour-bar index of the
// current input pixel (combinational from registered state); an active pixel at x=0 restarts the line.
module bar_index_counter #(
  parameter int COORD_W  = 16,
  parameter int H_ACTIVE = 640
) (
  input  logic               i_pix_clk,
  input  logic               i_reset_n,
  input  logic [COORD_W-1:0] i_horz_coord,
  input  logic               i_in_active_area,
  output logic [2:0]         o_bar_idx
);

  localparam int BW = H_ACTIVE / 8;
  localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [2:0]       bar_q, bar_d, bar_cur;
  logic             line_start;

  assign line_start = i_in_active_area && (i_horz_coord == '0);

  // Pixel-in-bar counter replaces a divide by BW
  always_comb begin
    cnt_cur = line_start ? '0 : cnt_q;
    bar_cur = line_start ? '0 : bar_q;
    cnt_d   = cnt_q;
    bar_d   = bar_q;
    if (i_in_active_area) begin
      if (cnt_cur == CNT_LAST) begin
        cnt_d = '0;
        bar_d = (bar_cur == 3'd7) ? 3'd7 : bar_cur + 3'd1;
      end else begin
        cnt_d = cnt_cur + CNT_W'(1);
        bar_d = bar_cur;
      end
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
      bar_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bar_q <= bar_d;
    end
  end

  assign o_bar_idx = bar_cur;

endmodule

// File: rtl/test_pattern_gen.sv
// Registered multi-mode VGA test pattern generator, fixed 2-cycle latency, no backpressure.
// Mode and frame counter change only at end-of-frame, so each frame renders one consistent pattern.
module test_pattern_gen
  import vga_pkg::*;
#(
  parameter int COORD_W     = 16,
  parameter int RED_W       = 3,
  parameter int GREEN_W     = 3,
  parameter int BLUE_W      = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CHECK_LOG2  = 5,
  parameter int FRAME_CNT_W = 8,
  parameter int SCROLL_STEP = 1
) (
  input  logic                   i_pix_clk,
  input  logic                   i_reset_n,
  input  logic [COORD_W-1:0]     i_horz_coord,
  input  logic [COORD_W-1:0]     i_vert_coord,
  input  logic                   i_in_active_area,
  input  logic [1:0]             i_mode,
  input  logic                   i_pause,
  output logic [RED_W-1:0]       o_red,
  output logic [GREEN_W-1:0]     o_green,
  output logic [BLUE_W-1:0]      o_blue,
  output logic                   o_active,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] SCROLL_INC = COORD_W'(SCROLL_STEP);

  // Stage 1
  logic [COORD_W-1:0] h_q, v_q, hs_q, hs_d;
  logic               act_q;
  logic [2:0]         bar_q, bar_idx;

  // Frame-level state
  mode_e                  mode_q, mode_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   eof;

  // Stage 2
  logic [RED_W-1:0]   red_q, red_d;
  logic [GREEN_W-1:0] green_q, green_d;
  logic [BLUE_W-1:0]  blue_q, blue_d;
  logic               act2_q;

  logic [COORD_W-1:0] grad_h;
  rgb_en_t            bar_en;
  logic               tile;

  bar_index_counter #(
    .COORD_W  (COORD_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_index_counter (
    .i_pix_clk        (i_pix_clk),
    .i_reset_n        (i_reset_n),
    .i_horz_coord     (i_horz_coord),
    .i_in_active_area (i_in_active_area),
    .o_bar_idx        (bar_idx)
  );

  // Falling edge of active on the last visible line marks end-of-frame
  assign eof = act_q && !i_in_active_area && (v_q == V_LAST);

  assign hs_d        = i_horz_coord + COORD_W'(frame_cnt_q) * SCROLL_INC;
  assign mode_d      = eof ? mode_e'(i_mode) : mode_q;
  assign frame_cnt_d = (eof && !i_pause) ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_q         <= '0;
      v_q         <= '0;
      hs_q        <= '0;
      act_q       <= 1'b0;
      bar_q       <= '0;
      mode_q      <= MODE_GRADIENT;
      frame_cnt_q <= '0;
    end else begin
      h_q         <= i_horz_coord;
      v_q         <= i_vert_coord;
      hs_q        <= hs_d;
      act_q       <= i_in_active_area;
      bar_q       <= bar_idx;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign grad_h = (mode_q == MODE_SCROLL) ? hs_q : h_q;
  assign bar_en = bar_colour(bar_q);
  assign tile   = h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2];

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    case (mode_q)
      MODE_GRADIENT, MODE_SCROLL: begin
        red_d   = grad_h[4 +: RED_W];
        green_d = v_q[4 +: GREEN_W];
        blue_d  = grad_h[6 +: BLUE_W] ^ v_q[5 +: BLUE_W];
      end
      MODE_BARS: begin
        red_d   = {RED_W{bar_en[2]}};
        green_d = {GREEN_W{bar_en[1]}};
        blue_d  = {BLUE_W{bar_en[0]}};
      end
      MODE_CHECKER: begin
        red_d   = {RED_W{tile}};
        green_d = {GREEN_W{tile}};
        blue_d  = {BLUE_W{tile}};
      end
      default: ;
    endcase
    if (!act_q) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      act2_q  <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      act2_q  <= act_q;
    end
  end

  // Only a few coordinate bits feed the patterns
  logic unused_bits;
  assign unused_bits = ^{h_q, hs_q};

  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;
  assign o_active      = act2_q;
  assign o_frame_count = frame_cnt_q;

endmodule
